number_cruncher_n: RTL

//   Parametrised successor to the 4-bit number cruncher: single-cycle accumulator CPU

---
 rtl/number_cruncher_n.sv | 106 ++++++++++
 1 files changed

// File: rtl/number_cruncher_n.sv
// Single-cycle accumulator CPU: A/B/O registers, carry/zero flags, conditional jumps,
// sticky halt and run/stall control, fetching from a combinational program memory.
module number_cruncher_n #(
   parameter int DATA_W = 4,
   parameter int PC_W   = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  run,
   output logic [PC_W-1:0]       pc,
   input  logic [4+DATA_W-1:0]   instr,
   output logic [DATA_W-1:0]     out_data,
   output logic                  out_valid,
   output logic                  flag_c,
   output logic                  flag_z,
   output logic                  halted
);

   localparam int INSTR_W = 4 + DATA_W;

   typedef enum logic [3:0] {
      OP_NOP  = 4'h0,
      OP_LDA  = 4'h1,
      OP_LDB  = 4'h2,
      OP_ADD  = 4'h3,
      OP_SUB  = 4'h4,
      OP_MOVB = 4'h5,
      OP_OUT  = 4'h6,
      OP_JMP  = 4'h7,
      OP_JC   = 4'h8,
      OP_JZ   = 4'h9,
      OP_JNC  = 4'hA,
      OP_HLT  = 4'hB
   } opcode_t;

   logic [DATA_W-1:0] a_q;
   logic [DATA_W-1:0] b_q;

   opcode_t           op;
   logic [DATA_W-1:0] imm;
   logic [PC_W-1:0]   pc_inc;
   logic [PC_W-1:0]   jump_pc;
   logic [DATA_W:0]   sum;
   logic [DATA_W-1:0] diff;
   logic              ex;

   always_comb begin
      op      = opcode_t'(instr[INSTR_W-1 -: 4]);
      imm     = instr[DATA_W-1:0];
      pc_inc  = pc + PC_W'(1);
      jump_pc = imm[PC_W-1:0];
      sum     = {1'b0, a_q} + {1'b0, b_q};
      diff    = a_q - b_q;
      ex      = run & ~halted;
   end

   // NOTE: all architectural state lives in this one block and uses non-blocking
   // assignments, so every read below sees the value from before the current edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc        <= '0;
         a_q       <= '0;
         b_q       <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
         flag_c    <= 1'b0;
         flag_z    <= 1'b0;
         halted    <= 1'b0;
      end else begin
         // NOTE: default-low each edge makes out_valid a pulse that only OUT re-arms.
         out_valid <= 1'b0;
         if (ex) begin
            pc <= pc_inc;
            case (op)
               OP_LDA:  a_q <= imm;
               OP_LDB:  b_q <= imm;
               OP_ADD: begin
                  a_q    <= sum[DATA_W-1:0];
                  flag_c <= sum[DATA_W];
                  flag_z <= (sum[DATA_W-1:0] == '0);
               end
               OP_SUB: begin
                  a_q    <= diff;
                  flag_c <= (a_q >= b_q);
                  flag_z <= (a_q == b_q);
               end
               OP_MOVB: b_q <= a_q;
               OP_OUT: begin
                  out_data  <= a_q;
                  out_valid <= 1'b1;
               end
               OP_JMP:  pc <= jump_pc;
               OP_JC:   if (flag_c)  pc <= jump_pc;
               OP_JZ:   if (flag_z)  pc <= jump_pc;
               OP_JNC:  if (!flag_c) pc <= jump_pc;
               OP_HLT: begin
                  halted <= 1'b1;
                  pc     <= pc;
               end
               default: ;  // NOP and reserved opcodes only advance pc
            endcase
         end
      end
   end

endmodule
